// File: rtl/bus_term_pkg.sv
// Purpose : shared constants and helpers for the bus terminal FIFO.
// Contents: broadcast ID default, error-flag bit indices, and dest_of(),
//           which extracts the 8-bit destination ID from a packet.
package bus_term_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned ERR_W     = 2;
  localparam int unsigned DROP_W    = 16;
  localparam int unsigned PKT_W_MAX = 64;

  localparam logic [ID_W-1:0] BCAST_ID_DEFAULT = 8'hFF;

  // Bit positions inside the sticky err vector
  localparam int unsigned ERR_TX_OVF    = 0;
  localparam int unsigned ERR_POP_EMPTY = 1;

  // Destination ID is the top ID_W bits of a pkt_w-bit packet.
  // The packet is passed zero-extended to PKT_W_MAX bits.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_W_MAX-1:0] pkt,
                                              input int unsigned           pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_terminal_fifo_if.sv
// Purpose : host/arbiter-facing handshake bundle of one bus terminal.
// Modports: master - host + arbiter side (drives writes, pops, pushes, rx_ready)
//           slave  - the terminal itself (drives flags, heads, counters)
// Signals : host_wr/host_wdata/host_full   host -> TX FIFO
//           pndng/D_pop/pop                TX FIFO -> arbiter
//           push/D_push                    arbiter -> RX FIFO
//           rx_valid/rx_data/rx_ready      RX FIFO -> host
//           tx_count, rx_drop_cnt, err     status
interface bus_terminal_fifo_if #(
  parameter int unsigned pckg_sz = 20,
  parameter int unsigned depth   = 16
);

  localparam int unsigned CNT_W = $clog2(depth) + 1;

  logic               host_wr;
  logic [pckg_sz-1:0] host_wdata;
  logic               host_full;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_valid;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_ready;
  logic [CNT_W-1:0]   tx_count;
  logic [15:0]        rx_drop_cnt;
  logic [1:0]         err;

  modport master (
    output host_wr, host_wdata, pop, push, D_push, rx_ready,
    input  host_full, pndng, D_pop, rx_valid, rx_data, tx_count, rx_drop_cnt, err
  );

  modport slave (
    input  host_wr, host_wdata, pop, push, D_push, rx_ready,
    output host_full, pndng, D_pop, rx_valid, rx_data, tx_count, rx_drop_cnt, err
  );

endinterface

// File: rtl/bus_term_sync_fifo.sv
// Purpose : synchronous first-word-fall-through FIFO with occupancy counter.
// Ports   : clk, reset (sync, active-high)
//           wr/wdata  write request; accepted when not full, or when full
//                     together with an effective read
//           rd        read request; ignored when empty
//           rdata     registered head; holds its last value when empty
//           empty/full/count  registered occupancy status
module bus_term_sync_fifo #(
  parameter int unsigned width = 20,
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [width-1:0]         wdata,
  input  logic                     rd,
  output logic [width-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;
  logic [width-1:0] r_rdata;

  logic             w_rd_en;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [width-1:0] w_head_nxt;

  // Next-state: effective enables, occupancy and the head value after this edge
  always_comb begin
    w_rd_en      = rd & ~r_empty;
    w_wr_en      = wr & (~r_full | w_rd_en);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_en);
    w_count_nxt  = r_count;
    w_head_nxt   = r_rdata;

    if (w_wr_en && !w_rd_en) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_rd_en && !w_wr_en) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    // When the slot being written becomes the head it is not in r_mem yet,
    // so forward wdata; an empty result keeps the previous head.
    if (w_count_nxt != '0) begin
      if (w_wr_en && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = wdata;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // Pointers, occupancy, flags and registered head
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == CNT_W'(depth));
      r_rdata  <= w_head_nxt;
    end
  end

  // Storage array; contents are meaningless outside the occupied window
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  assign rdata = r_rdata;
  assign empty = r_empty;
  assign full  = r_full;
  assign count = r_count;

endmodule

// File: rtl/bus_terminal_fifo.sv
// Purpose : per-terminal buffer around the bus arbiter. TX queues host packets
//           and presents them on pndng/D_pop; RX captures arbiter deliveries,
//           optionally filters on destination ID, and queues them for the host.
// Ports   : clk, reset (sync, active-high), bus (bus_terminal_fifo_if.slave)
// Config  : BUS_TERMINAL_ADDR_FILTER_EN - when defined, RX accepts only packets
//           whose destination is id or broadcast; otherwise every push is
//           accepted. TX is identical in both builds.
module bus_terminal_fifo
  import bus_term_pkg::*;
#(
  parameter int unsigned     pckg_sz   = 20,
  parameter int unsigned     depth     = 16,
  parameter logic [ID_W-1:0] id        = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_terminal_fifo_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(depth) + 1;

`ifdef BUS_TERMINAL_ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic               w_tx_empty;
  logic               w_tx_full;
  logic [pckg_sz-1:0] w_tx_rdata;
  logic [CNT_W-1:0]   w_tx_count;

  logic               w_rx_empty;
  logic               w_rx_full;
  logic [pckg_sz-1:0] w_rx_rdata;
  logic [CNT_W-1:0]   w_rx_count;

  logic [ID_W-1:0]    w_dest;
  logic               w_dest_match;
  logic               w_rx_accept;
  logic               w_rx_deq;
  logic               w_rx_drop;

  logic [ERR_W-1:0]   r_err;
  logic [DROP_W-1:0]  r_drop_cnt;

  // TX path: host -> arbiter
  bus_term_sync_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (bus.host_wr),
    .wdata (bus.host_wdata),
    .rd    (bus.pop),
    .rdata (w_tx_rdata),
    .empty (w_tx_empty),
    .full  (w_tx_full),
    .count (w_tx_count)
  );

  // RX acceptance: destination filter is bypassed in the unfiltered build
  always_comb begin
    w_dest       = dest_of(PKT_W_MAX'(bus.D_push), pckg_sz);
    w_dest_match = (w_dest == id) || (w_dest == broadcast);
    w_rx_accept  = bus.push & (~FILTER_EN | w_dest_match);
    w_rx_deq     = bus.rx_ready & (w_rx_count != '0);
    // A same-cycle dequeue frees a slot, so only a stalled full FIFO drops
    w_rx_drop    = w_rx_accept & w_rx_full & ~w_rx_deq;
  end

  // RX path: arbiter -> host
  bus_term_sync_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (w_rx_accept),
    .wdata (bus.D_push),
    .rd    (bus.rx_ready),
    .rdata (w_rx_rdata),
    .empty (w_rx_empty),
    .full  (w_rx_full),
    .count (w_rx_count)
  );

  // Sticky error flags and saturating RX drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err      <= '0;
      r_drop_cnt <= '0;
    end else begin
      // A pop while full is always effective, so it makes room for the write
      if (bus.host_wr && w_tx_full && !bus.pop) begin
        r_err[ERR_TX_OVF] <= 1'b1;
      end
      if (bus.pop && w_tx_empty) begin
        r_err[ERR_POP_EMPTY] <= 1'b1;
      end
      if (w_rx_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  assign bus.host_full   = w_tx_full;
  assign bus.pndng       = ~w_tx_empty;
  assign bus.D_pop       = w_tx_rdata;
  assign bus.tx_count    = w_tx_count;
  assign bus.rx_valid    = ~w_rx_empty;
  assign bus.rx_data     = w_rx_rdata;
  assign bus.rx_drop_cnt = r_drop_cnt;
  assign bus.err         = r_err;

endmodule

// File: doc/bus_terminal_fifo.md
Name: bus_terminal_fifo

Overview:
- Per-terminal buffer that sits directly upstream and downstream of bs_gnrtr_n_rbtr.
- The TX side queues packets from the host and presents them to the bus on pndng/D_pop, which the arbiter consumes via pop.
- The RX side captures bus deliveries (push/D_push), filters them by destination ID, and queues them for the host.
- One instance per driver slot; a bank of drvrs instances replaces the bench-side FIFO model.

Parameters:
- pckg_sz, 20, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID, the lower bits hold the payload.
- depth, 16, entries per FIFO; power of two, at least 2.
- id, 0, 8-bit ID of this terminal.
- broadcast, 8'hFF, broadcast destination ID.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- host_wr  in  1  host writes host_wdata into the TX FIFO.
- host_wdata  in  pckg_sz  packet from the host.
- host_full  out  1  TX FIFO full.
- pndng  out  1  TX FIFO not empty (to arbiter).
- D_pop  out  pckg_sz  TX head packet, first-word-fall-through (to arbiter).
- pop  in  1  arbiter consumes the TX head.
- push  in  1  arbiter delivers D_push to this terminal.
- D_push  in  pckg_sz  delivered packet.
- rx_valid  out  1  RX FIFO head valid.
- rx_data  out  pckg_sz  RX head packet.
- rx_ready  in  1  host accepts the RX head.
- tx_count  out  $clog2(depth)+1  TX occupancy.
- rx_drop_cnt  out  16  saturating count of RX packets dropped because the RX FIFO was full.
- err  out  2  sticky flags: [0] TX overflow, [1] pop on empty.

Behaviour:
- Reset (synchronous, active-high): both FIFOs empty; pointers and counts 0; pndng=0, rx_valid=0, host_full=0, D_pop=0, rx_data=0, rx_drop_cnt=0, err=0.
- Reset mid-operation discards all contents. Inputs are ignored during the reset cycle.
- TX latency: a write accepted at edge N raises pndng and shows the packet on D_pop after edge N (visible cycle N+1). Ordering is FIFO.
- TX head: D_pop always equals the head entry while pndng=1, and holds its last value when empty.
- pop while pndng=1 removes the head. The next entry appears the following cycle; pndng drops the same cycle the last entry leaves.
- pop while empty: ignored, sets err[0+1]=err[1].
- host_wr while full without a same-cycle pop: data dropped, err[0] set, count unchanged.
- host_wr and pop in the same cycle while full: both take effect, count stays at depth.
- host_wr and pop in the same cycle while empty: the write is accepted and the pop is an error (err[1]).
- tx_count: +1 on a write only, -1 on a pop only, unchanged on both; range 0..depth.
- RX acceptance: when push=1 the packet is accepted if dest==id or dest==broadcast (see Optional Feature). Otherwise it is silently discarded.
- RX full: an accepted packet arriving while the RX FIFO is full is dropped and rx_drop_cnt increments, saturating at 16'hFFFF.
- RX simultaneous events: a push and a host dequeue (rx_valid & rx_ready) in the same cycle while full are both honoured, so nothing is dropped.
- RX handshake: rx_valid/rx_data follow the same fall-through rule as TX. The head is removed on rx_valid & rx_ready. rx_ready while empty is ignored (no error).
- Pointers wrap modulo depth. Full/empty are derived from an occupancy counter, not from pointer equality alone.
- err bits clear only on reset.

Optional Feature:
- BUS_TERMINAL_ADDR_FILTER_EN defined: destination filtering as described above.
- BUS_TERMINAL_ADDR_FILTER_EN undefined: every push is accepted regardless of destination, and the id/broadcast parameters have no effect on RX. The TX path is identical in both builds.

Decomposition:
- Package bus_term_pkg holds:
  - BCAST_ID_DEFAULT = 8'hFF;
  - the function dest_of(pkt) returning the top 8 bits;
  - err bit index constants ERR_TX_OVF=0 and ERR_POP_EMPTY=1.
- Sub-module bus_term_sync_fifo (parameters width, depth):
  - ports clk, reset, wr, wdata, rd, rdata, empty, full, count;
  - first-word-fall-through, with simultaneous read/write allowed when full;
  - instantiated twice, once for TX and once for RX.
- The top level adds error flags, filtering and the drop counter.

Test Plan:
- Reset, then host_wr of 20'h2_0008 at cycle 1 -> pndng=1 and D_pop=20'h2_0008 at cycle 2; pop at cycle 3 -> pndng=0 at cycle 4, tx_count=0.
- 17 consecutive writes with depth=16 and no pops -> host_full=1 after the 16th write, 17th dropped, err=2'b01. Then 16 pops -> packets returned in order, with pndng falling after the 16th.
- Full TX with host_wr and pop in the same cycle -> tx_count stays 16 and the new packet is last out. Pop on an empty FIFO -> err[1]=1, with no change to D_pop.
- id=3, filter enabled: push with D_push destinations 8'h03, 8'hFF and 8'h05 -> rx_valid with the 03 and FF packets in order, 05 discarded, rx_drop_cnt=0.
- rx_ready held low and 18 matching pushes -> 16 stored, rx_drop_cnt=2. A push and an rx_ready dequeue in the same cycle while full -> no drop.
- Reset asserted mid-stream with 5 TX and 3 RX entries -> next cycle pndng=0, rx_valid=0, counts 0, err=0. Repeat with BUS_TERMINAL_ADDR_FILTER_EN undefined -> the dest 8'h05 packet is accepted.
